// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_seq_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  // Two's-complement negate when neg is set; the same helper serves product and quotient/remainder.
  function automatic logic [2*XLEN-1:0] sign_fix(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One iteration of the datapath: shift-add multiply or restoring trial-subtract divide.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic            is_div_i,
  input  logic [XLEN:0]   acc_i,
  input  logic            lo_bit_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   acc_o,
  output logic            bit_o
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;

  always_comb begin
    sum   = acc_i + {1'b0, (lo_bit_i ? opnd_i : '0)};
    // One extra bit beyond the accumulator so the borrow is exact even when the shifted remainder exceeds XLEN bits
    diff  = {acc_i, lo_bit_i} - {2'b00, opnd_i};
    bit_o = 1'b0;
    acc_o = '0;
    if (is_div_i) begin
      bit_o = ~diff[XLEN+1];
      acc_o = bit_o ? diff[XLEN:0] : {acc_i[XLEN-1:0], lo_bit_i};
    end else begin
      bit_o = sum[0];
      acc_o = {1'b0, sum[XLEN:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide: IDLE/CALC/DONE sequencer, operand/sign capture and final sign fix-up.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN:0]   acc_q, acc_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, last_iter, is_div_q;
  logic            sign_a, sign_b, neg_new, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic [XLEN:0]   acc_step;
  logic            bit_step;
  logic [XLEN-1:0] lo_step, final_res;
  logic [2*XLEN-1:0] prod_fix;

  assign accept    = (state_q == IDLE) && start && !flush;
  assign last_iter = (count_q == 5'd31);
  assign is_div_q  = op_q[2];

  // Operand decode for the instruction being accepted
  always_comb begin
    sign_a   = srca[XLEN-1] && (funct3 != OP_MULHU) && (funct3 != OP_DIVU) && (funct3 != OP_REMU);
    sign_b   = srcb[XLEN-1] && (funct3 inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    mag_a    = sign_a ? -srca : srca;
    mag_b    = sign_b ? -srcb : srcb;
    case (funct3)
      OP_MUL, OP_MULH, OP_DIV: neg_new = sign_a ^ sign_b;
      OP_MULHSU, OP_REM:       neg_new = sign_a;
      default:                 neg_new = 1'b0;
    endcase
    div_zero = funct3[2] && (srcb == '0);
    div_ovf  = funct3[2] && !funct3[0] && (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = funct3[1] ? srca : '1;
    else          special_res = funct3[1] ? '0 : srca;
  end

  muldiv_step u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .lo_bit_i (is_div_q ? lo_q[XLEN-1] : lo_q[0]),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step),
    .bit_o    (bit_step)
  );

  always_comb begin
    lo_step  = is_div_q ? {lo_q[XLEN-2:0], bit_step} : {bit_step, lo_q[XLEN-1:1]};
    prod_fix = sign_fix(neg_q, {acc_step[XLEN-1:0], lo_step});
    case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = sign_fix(neg_q, {{XLEN{1'b0}}, lo_step}) >> 0;
      default:                       final_res = sign_fix(neg_q, {{XLEN{1'b0}}, acc_step[XLEN-1:0]}) >> 0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = special ? DONE : CALC;
        CALC:    if (last_iter) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    stall = accept || (state_q == CALC);
    done  = (state_q == DONE);
  end

  always_comb begin
    count_d  = count_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      op_d    = funct3;
      opnd_d  = mag_b;
      lo_d    = mag_a;
      acc_d   = '0;
      neg_d   = neg_new;
      count_d = '0;
      if (special) result_d = special_res;
    end else if ((state_q == CALC) && !flush) begin
      acc_d   = acc_step;
      lo_d    = lo_step;
      count_d = count_q + 5'd1;
      if (last_iter) result_d = final_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      result_q <= '0;
    end else begin
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    opnd_q <= opnd_d;
    lo_q   <= lo_d;
    acc_q  <= acc_d;
    neg_q  <= neg_d;
  end

  assign result = result_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide unit for the pipelined core, sitting beside the main ALU in the Execute stage. It sequences a one-bit-per-cycle shift-add / restoring-divide datapath through a small FSM. It handles RISC-V signedness and the divide special cases, and drives the stall the hazard unit uses to hold Execute until the result is ready.

## Interface
- XLEN, 32, operand/result width (only 32 is supported)
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  M-extension instruction in Execute (level; sampled only in IDLE)
- funct3  in  3  op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- srca, srcb  in  XLEN  forwarded operands, sampled with start
- flush  in  1  Execute flush (branch mispredict); aborts operation
- stall  out  1  hold F/D/E stages
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered result

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start & !flush → capture funct3, operand magnitudes, sign flags; count=0.
  - Go to DONE if special case, else CALC.
- CALC: one iteration per cycle; count 0..31; after count==31 → DONE.
- DONE: done=1; result holds final value; → IDLE. start is ignored in DONE; it belongs to the completing instruction.
- Multiply:
  - unsigned 32×32 shift-add on magnitudes gives a 64-bit product.
  - negate if result sign set: mul/mulh use sa^sb, mulhsu uses sa, mulhu uses 0.
  - mul returns low 32 bits; others return high 32 bits.
  - mulhsu treats srcb as unsigned.
- Divide:
  - restoring division on magnitudes (div/rem signed; divu/remu unsigned).
  - quotient sign = sa^sb; remainder sign = sa (dividend).
- Special cases (detected in IDLE; no CALC cycles):
  - divisor 0: quotient 0xFFFFFFFF, remainder = srca.
  - signed overflow (div/rem with srca=0x80000000, srcb=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Sign fix-up (two's-complement negate) is applied on the CALC→DONE transition, so result is registered when done rises.
- Arithmetic:
  - accumulator/remainder registers are XLEN+1 bits wide to hold the carry/borrow.
  - magnitude of 0x80000000 is 0x80000000 unsigned (no overflow).
- flush: any state → IDLE next cycle; no done; result unchanged. flush has priority over start in the same cycle.
- reset: state IDLE, count 0, stall 0, done 0, result 0.

## Timing
- Cycle 0 = cycle with start high in IDLE.
- Normal op: CALC cycles 1..32, DONE at cycle 33; done and result valid at cycle 33.
- Special case: DONE at cycle 1.
- stall = (IDLE & start & !flush) | CALC. It is combinational from state and start, so the hazard unit holds the instruction from cycle 0.
- stall is 0 in DONE, so the instruction advances with result that cycle.
- A back-to-back M instruction raises start at cycle 34 (IDLE) and is accepted; there is no lost cycle beyond DONE→IDLE.
- Operands are captured only at cycle 0; srca/srcb changes during CALC have no effect.

## Structure
- Shared package:
  - funct3 M-op encodings.
  - state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10).
  - XLEN constant.
- Sub-module muldiv_step: combinational single iteration (shift-add or trial-subtract). Takes accumulator, multiplicand/divisor and mode; returns next accumulator and the quotient bit.
- Top level holds the FSM, counter, operand/sign registers and sign fix-up.

## Test plan
- mul 7 × 0xFFFFFFFD → result 0xFFFFFFEB; stall high cycles 0..32; done only at cycle 33.
- mulh 0x80000000×0x80000000 → 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- div 0xFFFFFFF9 / 2 → 0xFFFFFFFD; rem → 0xFFFFFFFF; divu 100/7 → 14; remu → 2.
- Special cases:
  - div 5/0 → 0xFFFFFFFF with done at cycle 1.
  - rem 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - rem of the same operands → 0.
- flush at CALC cycle 10 → IDLE next cycle, stall 0, no done, result unchanged. start+flush together → not accepted. A new start the following cycle completes correctly.
- reset asserted mid-CALC → next cycle state IDLE, stall 0, done 0, result 0. Back-to-back mul then divu: second done exactly 34 cycles after the first.
